mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port, word-aligned core memory between the instruction-fetch
//  port and the load/store port of the core. Arbitrates per cycle with data priority
//  plus an anti-starvation override for fetch. Sequences sub-word stores as a
//  two-cycle read-modify-write, because the memory only supports full-word writes.
//  Sits between the core's fetch/LSU and the memory array; its outputs drive the
//  memory's wen/addr/data_i and it receives the memory's data_o.
// PARAMETERS
//  WORDSIZE      32  data width; byte enables are WORDSIZE/8 bits
//  STARVE_LIMIT  4   consecutive lost fetch arbitrations before fetch gets priority
//  CNT_W         3   starvation counter width; must hold STARVE_LIMIT
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rst_n      in   1           synchronous active-low reset
//  i_req      in   1           fetch request; held until i_gnt
//  i_addr     in   32          fetch byte address; [1:0] ignored
//  i_gnt      out  1           fetch accepted this cycle (combinational)
//  i_rvalid   out  1           fetch data valid (registered)
//  i_rdata    out  WORDSIZE    fetch data
//  d_req      in   1           load/store request; held until d_gnt
//  d_we       in   1           1 = store, 0 = load
//  d_be       in   WORDSIZE/8  store byte enables
//  d_addr     in   32          data byte address; [1:0] ignored
//  d_wdata    in   WORDSIZE    store data, lane-aligned
//  d_gnt      out  1           data accepted this cycle (combinational)
//  d_rvalid   out  1           load data valid or store complete (registered)
//  d_rdata    out  WORDSIZE    load data; 0 on store acknowledge
//  mem_wen    out  1           memory write enable
//  mem_addr   out  32          memory address, always {addr[31:2],2'b00}
//  mem_wdata  out  WORDSIZE    memory write data
//  mem_rdata  in   WORDSIZE    memory combinational read data
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state<=IDLE, starve_cnt<=0, i/d_rvalid<=0,
//    i/d_rdata<=0. mem_wen, i_gnt and d_gnt are forced to 0 while rst_n=0.
//  - FSM states: IDLE, RMW_WR.
//  - IDLE arbitration:
//      * If starve_cnt==STARVE_LIMIT and i_req=1, fetch wins.
//      * Otherwise d_req wins over i_req.
//      * At most one gnt is asserted per cycle.
//  - starve_cnt:
//      * +1 on each IDLE cycle with i_req=1 and i_gnt=0 (saturates at the limit).
//      * Cleared on i_gnt or when i_req=0.
//      * Held in RMW_WR.
//  - Granted read (fetch or load): mem_addr = request address. mem_rdata is
//    registered into i_rdata/d_rdata, and rvalid pulses for 1 cycle on the
//    next cycle. Latency 1.
//  - Granted store, d_be all ones: mem_wen=1 in the grant cycle with
//    mem_wdata=d_wdata. d_rvalid is asserted on the next cycle.
//  - Granted store, d_be=0: no memory write; d_rvalid is asserted on the next cycle.
//  - Granted store, partial d_be:
//      * Grant cycle: read the word at the address. Latch address and merged
//        word (byte k = d_be[k] ? d_wdata byte k : mem_rdata byte k). Go to RMW_WR.
//      * RMW_WR: mem_wen=1, mem_addr/mem_wdata from the latches. No grants in
//        this cycle; a pending fetch counts as neither loss nor grant.
//        Return to IDLE.
//      * d_rvalid is asserted on the cycle after RMW_WR.
//  - A new grant may be issued in the same cycle that a previous rvalid is high
//    (back-to-back throughput of 1 per cycle, except partial stores at 1 per 2 cycles).
//  - Requester signals are sampled only in the grant cycle; changes after the
//    grant have no effect.
//  - Reset during RMW_WR: the write is aborted (mem_wen=0), the memory word is
//    unchanged, the FSM returns to IDLE, and no d_rvalid is issued.
// TESTING
//  1. mem[0x10]=0xDEADBEEF; i_req addr 0x10, d_req=0 -> i_gnt in same cycle;
//     i_rvalid=1 with i_rdata=0xDEADBEEF on the next cycle.
//  2. i_req and d_req (load 0x20=0x12345678) in the same cycle -> d_gnt=1, i_gnt=0;
//     d_rdata=0x12345678 on the next cycle; i_gnt on the next cycle.
//  3. d_req held high for 8 cycles, i_req held high -> i_gnt=0 for cycles 0-3,
//     i_gnt=1 on cycle 4, starve_cnt=0 on cycle 5.
//  4. mem[0x40]=0x11223344; store be=4'b0010 wdata=0x0000AA00 -> cycle N
//     mem_wen=0; N+1 mem_wen=1 with mem_wdata=0x1122AA44 and i_gnt=0 despite
//     i_req; N+2 d_rvalid=1; a read-back returns 0x1122AA44.
//  5. Partial store as in 4, rst_n=0 during RMW_WR -> mem_wen=0, mem[0x40] stays
//     0x11223344, no d_rvalid; after reset release a fetch is granted normally.
//  6. Full store be=4'hF 0xCAFEF00D to 0x80, then load 0x80 on the next cycle ->
//     mem_wen in the grant cycle only; the load returns 0xCAFEF00D.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the memory arbiter.
// The arbiter uses the slave view; the core/memory environment uses the master view.
interface mem_arbiter_if #(
    parameter int WORDSIZE = 32
);
    logic                  i_req;
    logic [31:0]           i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [WORDSIZE-1:0]   i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [WORDSIZE/8-1:0] d_be;
    logic [31:0]           d_addr;
    logic [WORDSIZE-1:0]   d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [WORDSIZE-1:0]   d_rdata;

    logic                  mem_wen;
    logic [31:0]           mem_addr;
    logic [WORDSIZE-1:0]   mem_wdata;
    logic [WORDSIZE-1:0]   mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_wen, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_wen, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory port between fetch and load/store, with data priority,
// a fetch anti-starvation override, and read-modify-write sequencing for sub-word stores.
module mem_arbiter #(
    parameter int WORDSIZE     = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int BE_W = WORDSIZE / 8;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    logic [0:0]          state;
    logic [CNT_W-1:0]    starve_cnt;
    logic [31:0]         rmw_addr;
    logic [WORDSIZE-1:0] rmw_data;
    logic [WORDSIZE-1:0] merged;
    logic                is_idle;
    logic                fetch_prio;
    logic                be_full;
    logic                be_zero;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    assign is_idle    = rst_n && (state == IDLE);
    assign fetch_prio = (starve_cnt == CNT_W'(STARVE_LIMIT)) && bus.i_req;
    assign be_full    = &bus.d_be;
    assign be_zero    = ~|bus.d_be;

    assign bus.d_gnt  = is_idle && bus.d_req && !fetch_prio;
    assign bus.i_gnt  = is_idle && bus.i_req && (fetch_prio || !bus.d_req);

    // The RMW write phase owns the memory port; reset suppresses its write.
    always_comb begin
        bus.mem_addr  = bus.d_gnt ? {bus.d_addr[31:2], 2'b00} : {bus.i_addr[31:2], 2'b00};
        bus.mem_wdata = bus.d_wdata;
        bus.mem_wen   = bus.d_gnt && bus.d_we && be_full;
        if (state == RMW_WR) begin
            bus.mem_addr  = rmw_addr;
            bus.mem_wdata = rmw_data;
            bus.mem_wen   = rst_n;
        end
    end

    always_comb begin
        merged = bus.mem_rdata;
        for (int k = 0; k < BE_W; k++) begin
            if (bus.d_be[k]) begin
                merged[8*k +: 8] = bus.d_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            bus.i_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.d_rvalid <= 1'b0;
            bus.d_rdata  <= '0;
        end else begin
            bus.i_rvalid <= bus.i_gnt;
            if (bus.i_gnt) begin
                bus.i_rdata <= bus.mem_rdata;
            end
            bus.d_rvalid <= 1'b0;
            if (state == RMW_WR) begin
                state        <= IDLE;
                bus.d_rvalid <= 1'b1;
                bus.d_rdata  <= '0;
            end else begin
                if (bus.d_gnt) begin
                    if (bus.d_we && !be_full && !be_zero) begin
                        state    <= RMW_WR;
                        rmw_addr <= {bus.d_addr[31:2], 2'b00};
                        rmw_data <= merged;
                    end else begin
                        bus.d_rvalid <= 1'b1;
                        bus.d_rdata  <= bus.d_we ? '0 : bus.mem_rdata;
                    end
                end
                // Only a fetch that is requesting and losing accumulates starvation.
                if (bus.i_gnt || !bus.i_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end
endmodule
